// File: rtl/fetch_unit_pkg.sv
// Shared constants, types and helpers for the instruction fetch stage.
package fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam int          FETCH_BUF_DEPTH  = 2;
    localparam logic [31:0] BAD_INSTR        = 32'hFFFF_FFFF;
    localparam logic [31:0] MEM_BYTES_IMEM   = 32'd256;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } fetch_state_e;

    // One buffered fetch result as handed to decode.
    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic [31:0] data;
    } fetch_entry_t;

    // A fetch address is bad if it is not word aligned or its word lies past the end of imem.
    function automatic logic pc_faults(input logic [31:0] pc, input logic [31:0] mem_bytes);
        return (pc[1:0] != 2'b00) || (pc > (mem_bytes - 32'd4));
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch stage and its neighbours (imem, redirect source, decode).
// Handshake: decode takes the head entry on a rising edge where inst_valid and inst_ready are
// both high; inst_valid never depends on inst_ready, and the head payload stays stable while
// inst_valid is high and inst_ready is low. redirect_valid is a single-cycle command, no ready.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_read_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_fault;

    modport master (
        output imem_addr, inst_valid, inst_data, inst_pc, inst_fault,
        input  imem_read_data, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_addr, inst_valid, inst_data, inst_pc, inst_fault,
        output imem_read_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetch results until decode accepts them.
// Flush empties it and overrides a simultaneous push; push and pop together on a full buffer is legal.
module fetch_buffer
    import fetch_unit_pkg::*;
#(
    parameter  int DEPTH = FETCH_BUF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  fetch_entry_t  push_entry,
    input  logic          pop,
    input  logic          flush,
    output fetch_entry_t  head_entry,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop     = pop && (count != '0);
    assign do_push    = push && ((count != CW'(DEPTH)) || do_pop);
    assign head_entry = mem[rd_ptr];

    // Storage, pointers and occupancy; flush wins over push/pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues imem reads, buffers responses for decode,
// and restarts at a new PC on redirect. A bad fetch address parks the stage in FAULT.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] MEM_BYTES = MEM_BYTES_IMEM,
    parameter int          BUF_DEPTH = FETCH_BUF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus,
    output fetch_state_e  dbg_state
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_e  state;
    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic          inflight_fault;
    logic [CW-1:0] count;
    logic          head_valid;
    logic          pop;
    logic          issue;
    fetch_entry_t  push_entry;
    fetch_entry_t  head_entry;

    assign head_valid = (count != '0);
    assign pop        = head_valid && bus.inst_ready;

    // Only issue when the read is guaranteed a buffer slot after this edge's pop.
    assign issue = (state == ST_RUN) && !bus.redirect_valid &&
                   ((int'(count) + int'(inflight) - int'(pop)) < BUF_DEPTH);

    // A faulting fetch never trusts imem output.
    assign push_entry = '{fault: inflight_fault,
                          pc:    inflight_pc,
                          data:  inflight_fault ? BAD_INSTR : bus.imem_read_data};

    assign bus.imem_addr  = fetch_pc;
    assign bus.inst_valid = head_valid;
    assign bus.inst_data  = head_entry.data;
    assign bus.inst_pc    = head_entry.pc;
    assign bus.inst_fault = head_entry.fault;
    assign dbg_state      = state;

    // PC, in-flight tracking and RUN/FAULT control; redirect kills the in-flight read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_RUN;
            fetch_pc       <= RESET_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_fault <= 1'b0;
        end else if (bus.redirect_valid) begin
            state    <= ST_RUN;
            fetch_pc <= bus.redirect_pc;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc    <= fetch_pc;
                inflight_fault <= pc_faults(fetch_pc, MEM_BYTES);
                if (pc_faults(fetch_pc, MEM_BYTES)) begin
                    state <= ST_FAULT;
                end else begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
            end
        end
    end

    fetch_buffer #(
        .DEPTH(BUF_DEPTH)
    ) u_buffer (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (bus.redirect_valid),
        .head_entry (head_entry),
        .count      (count)
    );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the instruction memory: owns the program counter, drives the imem word address, captures the imem registered read data one cycle later, and presents {pc, instruction, fault} to decode over a valid/ready handshake. A small response buffer absorbs decode back-pressure without losing in-flight reads. A redirect port (branch/jump/trap) flushes everything and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000: PC loaded on reset.
- MEM_BYTES, `MEM_BYTES_IMEM: imem size in bytes; used for range checking.
- BUF_DEPTH, 2: response buffer entries (power of two, ≥2).
- clk  in  1  rising-edge clock shared with imem.
- rst  in  1  asynchronous, active-high reset.
- imem_addr  out  32  byte address to imem; always equals fetch_pc.
- imem_read_data  in  32  imem registered read word (little-endian); valid the cycle after the address is sampled.
- redirect_valid  in  1  restart fetch at redirect_pc this cycle.
- redirect_pc  in  32  new fetch address.
- inst_valid  out  1  buffer head holds a deliverable instruction.
- inst_ready  in  1  decode accepts head this cycle.
- inst_data  out  32  instruction word at head.
- inst_pc  out  32  byte address of inst_data.
- inst_fault  out  1  head is a fetch fault (misaligned or out of range).

## Operation
- States: RUN, FAULT. Reset → RUN.
- Issue: in RUN, a request for fetch_pc is issued on an edge when (count + inflight − pop) < BUF_DEPTH, where pop = inst_valid & inst_ready. On issue: inflight ← 1, inflight_pc ← fetch_pc, fetch_pc ← fetch_pc + 4 (mod 2^32).
- Response: if inflight was set at the previous edge and not killed, push {fault, inflight_pc, imem_read_data} at the next edge.
- Fault check at issue: fetch_pc[1:0] ≠ 0 or fetch_pc > MEM_BYTES−4 → entry pushed with fault=1, data=32'hFFFF_FFFF regardless of imem output; state → FAULT, no further issues, fetch_pc held.
- FAULT: buffer drains normally; leaves only on redirect.
- Redirect (highest priority): buffer flushed (count ← 0), in-flight response killed (discarded next edge), fetch_pc ← redirect_pc, state ← RUN. No issue on the redirect edge.
- Redirect and pop in the same cycle: the pop counts as accepted by decode; flush still applies.
- Push and pop in the same cycle with a full buffer: allowed; count unchanged.
- imem write enable is not driven by this block.

## Timing
- Reset values: inst_valid 0, inst_data 0, inst_pc 0, inst_fault 0, imem_addr RESET_PC, inflight 0, count 0, state RUN.
- First issue at the first rising edge after rst deasserts; inst_valid high after the second edge (2-cycle fetch latency).
- Redirect sampled at edge N → imem_addr = redirect_pc after N; issue at N+1; inst_valid with inst_pc = redirect_pc after N+2.
- Steady state with inst_ready held high: one instruction per cycle, PCs consecutive by +4.
- Outputs are registered from buffer head; inst_valid does not depend combinationally on inst_ready.
- inst_data/inst_pc/inst_fault stable while inst_valid & ~inst_ready.
- rst asserted mid-operation: all state returns to reset values immediately (asynchronous); pending responses are lost.

## Structure
- Shared constants in variables.vh: `RESET_PC`, `FETCH_BUF_DEPTH`, `BAD_INSTR` (32'hFFFF_FFFF), plus the existing `MEM_BYTES_IMEM`.
- One sub-module: fetch_buffer, a BUF_DEPTH-entry synchronous FIFO of {fault, pc[31:0], data[31:0]} with push, pop, flush, count; flush overrides push.
- fetch_unit holds the PC, inflight/kill flags, issue logic, and the RUN/FAULT state.

## Test plan
- Reset, RESET_PC=0, imem words 0x00000013,0x00100093,…, inst_ready=1 -> inst_valid after edge 2, then inst_pc 0x0,0x4,0x8… one per cycle, data matching memory.
- Hold inst_ready=0 for 5 cycles mid-stream -> exactly BUF_DEPTH entries held, no PC skipped or duplicated when ready returns.
- Redirect to 0x40 while buffer full and read in flight -> stale entries dropped; next delivered inst_pc = 0x40 two cycles later.
- Redirect to 0x42 -> one entry with inst_fault=1, inst_pc=0x42, inst_data=0xFFFFFFFF; no further deliveries until redirect to 0x0 resumes normally.
- Sequential fetch reaching MEM_BYTES−4 -> that word delivered normally, next entry pc=MEM_BYTES with inst_fault=1.
- Assert rst for one cycle mid-stream with inst_valid high -> inst_valid 0 immediately, fetch restarts at RESET_PC.
